div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for the EX stage of the pipelined CPU, serving MIPS DIV/DIVU. It runs beside the single-cycle ALU. It accepts a dividend and divisor with a start pulse, computes one quotient bit per clock by restoring shift-subtract, and writes quotient and remainder into HI/LO result registers. It signals completion with a one-cycle done pulse; hazard logic holds the pipeline while busy is high.

## Interface
Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports (clock and reset first):
- clk  input  1  single clock for all state; rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a divide; sampled only in IDLE.
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- dataA  input  WIDTH  dividend; sampled with start.
- dataB  input  WIDTH  divisor; sampled with start.
- busy  output  1  high from the edge that accepts start until the edge that raises done.
- done  output  1  one-cycle pulse; hi/lo/divzero are valid from this cycle onward.
- lo  output  WIDTH  quotient register.
- hi  output  WIDTH  remainder register.
- divzero  output  1  the last completed operation had dataB == 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, dataB≠0:
  - Latch |dataA| and |dataB| (absolute value only when sign=1).
  - Latch the quotient sign (A[31]^B[31]) and the remainder sign (A[31]), both gated by sign.
  - Clear the partial remainder and the counter; go to CALC; set busy=1.
- IDLE, start=1, dataB=0:
  - Go directly to DONE with lo=all-ones, hi=dataA (raw), divzero=1; set busy=1.
- CALC, each edge:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem using a WIDTH+1-bit subtraction.
  - If the result is non-negative, commit it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - Increment the counter; after WIDTH iterations go to FIX.
- FIX:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Write lo and hi; divzero=0; go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; go to IDLE. start is ignored in this cycle.
- Arithmetic rules:
  - All negations are two's complement modulo 2^WIDTH.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap and no flag.
- start while busy or in DONE: ignored. Operands are not re-sampled.
- hi/lo/divzero hold their values until the next FIX or divide-by-zero accept; IDLE never clears them.

## Timing
- Reset values: busy=0, done=0, lo=0, hi=0, divzero=0; state IDLE.
- Reset asserted mid-operation aborts immediately (asynchronous). All outputs return to reset values; no done pulse follows.
- Normal divide, with the start accepted at edge k:
  - Edges k+1..k+WIDTH perform the iterations.
  - Edge k+WIDTH+1 (FIX) writes hi/lo.
  - done is high in the cycle after edge k+WIDTH+1, i.e. it rises 33 edges after accept (WIDTH=32).
- Divide-by-zero: done rises on edge k+1, one edge after accept.
- busy behaviour:
  - Rises on edge k.
  - Falls on the edge that raises done, so it is low in the done cycle.
- Back-to-back operation: a new start is accepted no earlier than the IDLE cycle after done. Minimum spacing is 35 edges start-to-start.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned: sign=0, dataA=100, dataB=7, start for one cycle -> done rises 33 edges later; lo=14, hi=2, divzero=0; busy high for exactly 33 cycles.
- Signed negative: sign=1, dataA=0xFFFFFFF9 (-7), dataB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide-by-zero: dataA=0x1234, dataB=0 -> done one edge after accept; lo=0xFFFFFFFF, hi=0x1234, divzero=1.
  - A following divide 9/3 -> lo=3, hi=0, divzero=0.
- Signed overflow: sign=1, dataA=0x80000000, dataB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start while busy: second start at edge k+5 with dataA=50, dataB=5 -> ignored; first result (100/7) is produced with only one done pulse.
  - Unsigned 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- Reset mid-op: reset low at edge k+10 -> busy=0, hi=lo=0 immediately; no done. After release, 20/6 -> lo=3, hi=2.

Source files
------------

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between the EX stage and the divider
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             divzero;

  modport master (
    output start, sign, dataA, dataB,
    input  busy, done, lo, hi, divzero
  );

  modport slave (
    input  start, sign, dataA, dataB,
    output busy, done, lo, hi, divzero
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for MIPS DIV/DIVU, one quotient bit per clock
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             divzero_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // The shifted remainder can exceed WIDTH bits when the divisor's MSB is set,
  // so the trial keeps the bit shifted out of rem as its top bit.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    abs_a = (bus.sign && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
    abs_b = (bus.sign && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      divzero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.dataB == '0) begin
              lo_q      <= '1;
              hi_q      <= bus.dataA;
              divzero_q <= 1'b1;
              state     <= DONE;
            end else begin
              quo   <= abs_a;
              dvs   <= abs_b;
              rem   <= '0;
              cnt   <= '0;
              q_neg <= bus.sign & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
              r_neg <= bus.sign & bus.dataA[WIDTH-1];
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          lo_q      <= q_neg ? -quo : quo;
          hi_q      <= r_neg ? -rem : rem;
          divzero_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Entered straight from a divide-by-zero accept, done has not pulsed yet.
          if (!done_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.lo      = lo_q;
  assign bus.hi      = hi_q;
  assign bus.divzero = divzero_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized and directed self-checking bench for div_unit
module tb_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference result from plain arithmetic; 64-bit signed math makes the
  // most-negative / -1 case fall out naturally modulo 2^32.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sq = sa / sb; sr = sa % sb;
      q = sq[31:0]; r = sr[31:0]; dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  logic        m_busy, m_done, m_dz, p_dz;
  logic [31:0] m_lo, m_hi, p_lo, p_hi;
  int          m_left;

  // Timeline model: a normal divide reports 33 edges after accept, a zero divisor after 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_lo = 0; m_hi = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1;
        if (!p_dz) begin m_lo = p_lo; m_hi = p_hi; m_dz = 0; end
      end
    end else if (bus.start) begin
      ref_div(bus.sign, bus.dataA, bus.dataB, p_lo, p_hi, p_dz);
      m_busy = 1;
      if (p_dz) begin m_lo = p_lo; m_hi = p_hi; m_dz = 1; m_left = 1; end
      else m_left = 33;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.sign = s; bus.dataA = a; bus.dataB = b;
    @(negedge clk);
    bus.start = 1'b0; bus.dataA = $urandom; bus.dataB = $urandom; bus.sign = $urandom_range(0, 1);
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = bus.busy ? 1 : 0;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cycles++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_div(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_lo, input logic [31:0] e_hi, input logic e_dz, input int e_lat);
    int lat, bc;
    launch(s, a, b);
    wait_done(lat, bc);
    chk({nm, "_lo"}, bus.lo, e_lo);
    chk({nm, "_hi"}, bus.hi, e_hi);
    chk({nm, "_dz"}, {31'd0, bus.divzero}, {31'd0, e_dz});
    chk({nm, "_lat"}, lat, e_lat);
  endtask

  initial begin
    int lat, bc;
    logic [31:0] ra, rb, rq, rr;
    logic rs, rdz;
    bus.start = 0; bus.sign = 0; bus.dataA = 0; bus.dataB = 0;

    fork
      forever begin
        @(negedge clk);
        chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        chk("done", {31'd0, bus.done}, {31'd0, m_done});
        chk("lo", bus.lo, m_lo);
        chk("hi", bus.hi, m_hi);
        chk("divzero", {31'd0, bus.divzero}, {31'd0, m_dz});
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_dz", {31'd0, bus.divzero}, 32'd0);
    rst_n = 1'b1;

    ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, rq, rr, rdz);
    chk("model_neg_q", rq, 32'hFFFF_FFFD);
    chk("model_neg_r", rr, 32'hFFFF_FFFF);

    launch(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc);
    chk("u100_lo", bus.lo, 32'd14);
    chk("u100_hi", bus.hi, 32'd2);
    chk("u100_lat", lat, 33);
    chk("u100_busy_cycles", bc, 33);

    run_div("sneg", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    run_div("dz", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run_div("after_dz", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
    run_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);

    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dataA = 32'd50; bus.dataB = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bc);
    chk("busy_start_lo", bus.lo, 32'd14);
    chk("busy_start_hi", bus.hi, 32'd2);
    chk("busy_start_lat", lat, 28);

    run_div("max_div1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);

    launch(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run_div("post_rst", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 33);

    for (int i = 0; i < 40; i++) begin
      rs = $urandom_range(0, 1);
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ref_div(rs, ra, rb, rq, rr, rdz);
      launch(rs, ra, rb);
      if (rb != 0 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_done(lat, bc);
      chk("rnd_lo", bus.lo, rq);
      chk("rnd_hi", bus.hi, rr);
      chk("rnd_dz", {31'd0, bus.divzero}, {31'd0, rdz});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
